// File: rtl/clk_mux_sel_ctrl.sv
// Clock-mux select sequencer: gates the output clock, swaps the mux configuration,
// waits for the mux to settle, then re-enables the clock if requested.
module clk_mux_sel_ctrl #(
    parameter int unsigned GATE_CYC   = 4,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic       clk_i,
    input  logic       rstb_i,
    input  logic       prog_i,
    input  logic       req_i,
    input  logic [3:0] req_sel_i,
    input  logic       req_pol_i,
    input  logic       req_en_i,
    output logic [5:0] cbit_o,
    output logic [5:0] cbitb_o,
    output logic       cenb_o,
    output logic       busy_o,
    output logic       ack_o,
    output logic       err_o
);

    typedef enum logic [1:0] {StIdle, StGate, StSwitch, StSettle} state_e;

    localparam logic [7:0] GateLoad   = 8'(GATE_CYC - 1);
    localparam logic [7:0] SettleLoad = 8'(SETTLE_CYC - 1);
    localparam logic [5:0] CbitRst    = 6'b100000;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [5:0] cbit_q, cbit_d;
    logic [5:0] pend_q, pend_d;
    logic       rej_q, rej_d;
    logic       ack_q, ack_d;
    logic       err_q, err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cbit_d  = cbit_q;
        pend_d  = pend_q;
        rej_d   = 1'b0;
        ack_d   = 1'b0;
        // A rejected request reports its error one cycle after it is sampled.
        err_d   = rej_q;
        unique case (state_q)
            StIdle: begin
                if (req_i && !prog_i) begin
                    if (req_sel_i <= 4'd11) begin
                        pend_d  = {req_pol_i, req_en_i, req_sel_i};
                        cnt_d   = GateLoad;
                        state_d = StGate;
                    end else begin
                        rej_d = 1'b1;
                    end
                end
            end
            StGate: begin
                if (cnt_q == 8'd0) state_d = StSwitch;
                else               cnt_d   = cnt_q - 8'd1;
            end
            StSwitch: begin
                cbit_d  = pend_q;
                cnt_d   = SettleLoad;
                state_d = StSettle;
            end
            StSettle: begin
                if (cnt_q == 8'd0) begin
                    state_d = StIdle;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        // Abort; a commit already made on the SWITCH edge is kept.
        if (state_q != StIdle && prog_i) begin
            state_d = StIdle;
            cnt_d   = 8'd0;
            ack_d   = 1'b0;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstb_i) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            cbit_q  <= CbitRst;
            pend_q  <= CbitRst;
            rej_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cbit_q  <= cbit_d;
            pend_q  <= pend_d;
            rej_q   <= rej_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign busy_o  = (state_q != StIdle);
    assign cenb_o  = busy_o | prog_i | ~cbit_q[4];
    assign cbit_o  = cbit_q;
    assign cbitb_o = ~cbit_q;
    assign ack_o   = ack_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_clk_mux_sel_ctrl.sv
// Self-checking bench for clk_mux_sel_ctrl: a cycle-by-cycle vector table followed
// by hand-written abort, reset and same-configuration sequences.
module tb_clk_mux_sel_ctrl;

    typedef struct {
        logic       rb;
        logic       pr;
        logic       rq;
        logic [3:0] sel;
        logic       pol;
        logic       en;
        logic [5:0] cbit;
        logic       cenb;
        logic       busy;
        logic       ack;
        logic       err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       prog = 1'b0;
    logic       req = 1'b0;
    logic [3:0] req_sel = 4'd0;
    logic       req_pol = 1'b0;
    logic       req_en = 1'b0;
    logic [5:0] cbit, cbitb;
    logic       cenb, busy, ack, err;

    int checks = 0;
    int errors = 0;

    clk_mux_sel_ctrl #(.GATE_CYC(4), .SETTLE_CYC(2)) dut (
        .clk_i    (clk),
        .rstb_i   (rstb),
        .prog_i   (prog),
        .req_i    (req),
        .req_sel_i(req_sel),
        .req_pol_i(req_pol),
        .req_en_i (req_en),
        .cbit_o   (cbit),
        .cbitb_o  (cbitb),
        .cenb_o   (cenb),
        .busy_o   (busy),
        .ack_o    (ack),
        .err_o    (err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rb, pr, rq, input logic [3:0] sel,
                                input logic pol, en, input logic [5:0] cb,
                                input logic ce, bs, ak, er);
        vec_t v;
        v.rb = rb; v.pr = pr; v.rq = rq; v.sel = sel; v.pol = pol; v.en = en;
        v.cbit = cb; v.cenb = ce; v.busy = bs; v.ack = ak; v.err = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock once, sample just after the edge.
    task automatic step(input logic rb, pr, rq, input logic [3:0] sel, input logic pol, en);
        rstb = rb; prog = pr; req = rq; req_sel = sel; req_pol = pol; req_en = en;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [5:0] cb,
                           input logic ce, bs, ak, er);
        logic [5:0] cbb;
        cbb = ~cb;
        chk({tag, " cbit"}, cbit, cb);
        chk({tag, " cbitb"}, cbitb, cbb);
        chk({tag, " cenb"}, {5'd0, cenb}, {5'd0, ce});
        chk({tag, " busy"}, {5'd0, busy}, {5'd0, bs});
        chk({tag, " ack"}, {5'd0, ack}, {5'd0, ak});
        chk({tag, " err"}, {5'd0, err}, {5'd0, er});
    endtask

    vec_t vecs[26];

    initial begin
        // Row n: inputs held during the cycle, outputs expected just after its edge.
        // reset, then sel=3 pol=1 en=1
        vecs[0]  = mk(0, 0, 0, 4'd0, 0, 0, 6'b100000, 1, 0, 0, 0);
        vecs[1]  = mk(1, 0, 1, 4'd3, 1, 1, 6'b100000, 1, 1, 0, 0);  // k=0
        vecs[2]  = mk(1, 0, 0, 4'd0, 0, 0, 6'b100000, 1, 1, 0, 0);
        vecs[3]  = mk(1, 0, 0, 4'd0, 0, 0, 6'b100000, 1, 1, 0, 0);
        vecs[4]  = mk(1, 0, 0, 4'd0, 0, 0, 6'b100000, 1, 1, 0, 0);
        vecs[5]  = mk(1, 0, 0, 4'd0, 0, 0, 6'b100000, 1, 1, 0, 0);  // k=4
        vecs[6]  = mk(1, 0, 0, 4'd0, 0, 0, 6'b110011, 1, 1, 0, 0);  // k=5
        vecs[7]  = mk(1, 0, 0, 4'd0, 0, 0, 6'b110011, 1, 1, 0, 0);
        vecs[8]  = mk(1, 0, 0, 4'd0, 0, 0, 6'b110011, 0, 0, 1, 0);  // k=7
        vecs[9]  = mk(1, 0, 0, 4'd0, 0, 0, 6'b110011, 0, 0, 0, 0);
        // out-of-range select: err at k=1 only
        vecs[10] = mk(1, 0, 1, 4'd12, 1, 1, 6'b110011, 0, 0, 0, 0);
        vecs[11] = mk(1, 0, 0, 4'd0, 0, 0, 6'b110011, 0, 0, 0, 1);
        vecs[12] = mk(1, 0, 0, 4'd0, 0, 0, 6'b110011, 0, 0, 0, 0);
        // sel=7 pol=0 en=0 with an ignored second request at k=3
        vecs[13] = mk(1, 0, 1, 4'd7, 0, 0, 6'b110011, 1, 1, 0, 0);
        vecs[14] = mk(1, 0, 0, 4'd0, 0, 0, 6'b110011, 1, 1, 0, 0);
        vecs[15] = mk(1, 0, 0, 4'd0, 0, 0, 6'b110011, 1, 1, 0, 0);
        vecs[16] = mk(1, 0, 1, 4'd9, 1, 1, 6'b110011, 1, 1, 0, 0);  // k=3
        vecs[17] = mk(1, 0, 0, 4'd0, 0, 0, 6'b110011, 1, 1, 0, 0);
        vecs[18] = mk(1, 0, 0, 4'd0, 0, 0, 6'b000111, 1, 1, 0, 0);
        vecs[19] = mk(1, 0, 0, 4'd0, 0, 0, 6'b000111, 1, 1, 0, 0);
        vecs[20] = mk(1, 0, 0, 4'd0, 0, 0, 6'b000111, 1, 0, 1, 0);  // k=7
        vecs[21] = mk(1, 0, 0, 4'd0, 0, 0, 6'b000111, 1, 0, 0, 0);
        vecs[22] = mk(1, 0, 0, 4'd0, 0, 0, 6'b000111, 1, 0, 0, 0);
        // request under prog: ignored silently
        vecs[23] = mk(1, 1, 1, 4'd2, 1, 1, 6'b000111, 1, 0, 0, 0);
        vecs[24] = mk(1, 1, 0, 4'd0, 0, 0, 6'b000111, 1, 0, 0, 0);
        vecs[25] = mk(1, 0, 0, 4'd0, 0, 0, 6'b000111, 1, 0, 0, 0);

        @(negedge clk);
        for (int i = 0; i < 26; i++) begin
            step(vecs[i].rb, vecs[i].pr, vecs[i].rq, vecs[i].sel, vecs[i].pol, vecs[i].en);
            chk_all($sformatf("row%0d", i), vecs[i].cbit, vecs[i].cenb, vecs[i].busy,
                    vecs[i].ack, vecs[i].err);
        end

        // Abort: sel=5 en=1, prog visible from k=2, sampled at k=3
        step(1, 0, 1, 4'd5, 1, 1);
        step(1, 0, 0, 4'd0, 0, 0);
        step(1, 0, 0, 4'd0, 0, 0);
        chk_all("abort k2", 6'b000111, 1, 1, 0, 0);
        step(1, 1, 0, 4'd0, 0, 0);
        chk_all("abort k3", 6'b000111, 1, 0, 0, 1);
        step(1, 1, 0, 4'd0, 0, 0);
        chk_all("abort k4", 6'b000111, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 4'd0, 0, 0);
            chk_all($sformatf("abort tail%0d", i), 6'b000111, 1, 0, 0, 0);
        end

        // Reset at k=4 mid-sequence, with req and prog asserted on the same edge
        step(1, 0, 1, 4'd3, 1, 1);
        for (int i = 1; i <= 4; i++) step(1, 0, 0, 4'd0, 0, 0);
        chk_all("rst k4", 6'b000111, 1, 1, 0, 0);
        step(0, 1, 1, 4'd2, 1, 1);
        chk_all("rst k5", 6'b100000, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 4'd0, 0, 0);
            chk_all($sformatf("rst tail%0d", i), 6'b100000, 1, 0, 0, 0);
        end

        // Request equal to the current configuration runs the full sequence
        step(1, 0, 1, 4'd0, 1, 0);
        for (int k = 1; k <= 6; k++) begin
            step(1, 0, 0, 4'd0, 0, 0);
            chk_all($sformatf("same k%0d", k), 6'b100000, 1, 1, 0, 0);
        end
        step(1, 0, 0, 4'd0, 0, 0);
        chk_all("same k7", 6'b100000, 1, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
